// File: rtl/reg_bank_arbiter_if.sv
// Bus bundle for reg_bank_arbiter: write requesters, clear-sweep control and read port.
// The master side drives requests and commands; the slave side is the arbiter itself.
interface reg_bank_arbiter_if #(
    parameter int NREQ  = 3,
    parameter int WIDTH = 4,
    parameter int AW    = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ*AW-1:0]    wr_addr;
    logic [NREQ*WIDTH-1:0] wr_data;
    logic [NREQ-1:0]       gnt;
    logic                  clr_start;
    logic                  busy;
    logic                  done;
    logic [AW-1:0]         rd_addr;
    logic [WIDTH-1:0]      rd_data;

    modport master (
        output req, wr_addr, wr_data, clr_start, rd_addr,
        input  gnt, busy, done, rd_data
    );

    modport slave (
        input  req, wr_addr, wr_data, clr_start, rd_addr,
        output gnt, busy, done, rd_data
    );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Register bank shared by NREQ round-robin write requesters, with a one-register-per-cycle
// clear sweep and a combinational read port.
module reg_bank_arbiter #(
    parameter int NREQ  = 3,
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              reset,
    reg_bank_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t            state;
    state_t            state_next;
    logic [AW-1:0]     cnt;
    logic [IW-1:0]     last;
    logic [IW-1:0]     gnt_idx;
    logic [IW-1:0]     cand;
    logic              gnt_valid;
    logic              done_q;
    logic [NREQ-1:0]   gnt_vec;
    logic [AW-1:0]     sel_addr;
    logic [WIDTH-1:0]  sel_data;
    logic [WIDTH-1:0]  bank [DEPTH];

    // Round-robin search starting just after the last winner; a pending clear blocks grants.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = last;
        cand      = last;
        if (state == IDLE && !bus.clr_start) begin
            for (int i = 1; i <= NREQ; i++) begin
                cand = IW'((int'(last) + i) % NREQ);
                if (!gnt_valid && bus.req[cand]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
    end

    always_comb begin
        gnt_vec  = '0;
        sel_addr = '0;
        sel_data = '0;
        if (gnt_valid) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IW'(i)) begin
                sel_addr = bus.wr_addr[i*AW +: AW];
                sel_data = bus.wr_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.clr_start) state_next = SWEEP;
            SWEEP:   if (cnt == AW'(DEPTH - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The pointer only moves on a real grant, so it stays frozen across a sweep.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            last   <= IW'(NREQ - 1);
            done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else begin
            state  <= state_next;
            done_q <= (state == SWEEP) && (cnt == AW'(DEPTH - 1));
            if (state == SWEEP) begin
                bank[cnt] <= '0;
                cnt       <= cnt + 1'b1;
            end else begin
                cnt <= '0;
                if (gnt_valid) begin
                    bank[sel_addr] <= sel_data;
                    last           <= gnt_idx;
                end
            end
        end
    end

    assign bus.gnt     = gnt_vec;
    assign bus.busy    = (state == SWEEP);
    assign bus.done    = done_q;
    assign bus.rd_data = bank[bus.rd_addr];
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: arbitration order, clear sweep, async reset abort
// and same-address write ordering, each checked against hand-computed values.
module tb_reg_bank_arbiter;
    localparam int NREQ  = 3;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passes = 0;
    logic [WIDTH-1:0] pre [DEPTH];
    logic [NREQ-1:0]  rrExp [6];

    reg_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .AW(AW)) bus ();

    reg_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ*AW-1:0] a,
                                 input logic [NREQ*WIDTH-1:0] d, input logic c);
        bus.req       = r;
        bus.wr_addr   = a;
        bus.wr_data   = d;
        bus.clr_start = c;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic readCheck(input string tag, input logic [AW-1:0] addr,
                             input logic [WIDTH-1:0] expected);
        bus.rd_addr = addr;
        #1;
        checkOutput(tag, 32'(bus.rd_data), 32'(expected));
    endtask

    task automatic pulseReset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        pre   = '{4'hF, 4'hE, 4'hD, 4'hC};
        rrExp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        reset = 1'b0;
        bus.rd_addr = '0;
        applyStimulus('0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] reset state");
        checkOutput("rst_gnt",  32'(bus.gnt),     32'h0);
        checkOutput("rst_busy", 32'(bus.busy),    32'h0);
        checkOutput("rst_done", 32'(bus.done),    32'h0);
        checkOutput("rst_rd",   32'(bus.rd_data), 32'h0);
        reset = 1'b1;

        $display("[TB] single write");
        applyStimulus(3'b001, 6'b000010, 12'h00A, 1'b0);
        checkOutput("single_gnt", 32'(bus.gnt), 32'b001);
        readCheck("single_no_bypass", 2'd2, 4'h0);
        tick();
        applyStimulus('0, '0, '0, 1'b0);
        readCheck("single_rd", 2'd2, 4'hA);

        $display("[TB] round robin");
        pulseReset();
        applyStimulus(3'b111, 6'b100100, 12'h321, 1'b0);
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("rr_gnt%0d", k), 32'(bus.gnt), 32'(rrExp[k]));
            tick();
        end
        applyStimulus('0, '0, '0, 1'b0);
        readCheck("rr_rd0", 2'd0, 4'h1);
        readCheck("rr_rd1", 2'd1, 4'h2);
        readCheck("rr_rd2", 2'd2, 4'h3);
        readCheck("rr_rd3", 2'd3, 4'h0);

        $display("[TB] sweep with contention");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(3'b001, {4'b0, AW'(i)}, {8'b0, pre[i]}, 1'b0);
            checkOutput($sformatf("pre_gnt%0d", i), 32'(bus.gnt), 32'b001);
            tick();
        end
        applyStimulus(3'b010, 6'b000100, 12'h070, 1'b1);
        checkOutput("clr_gnt", 32'(bus.gnt), 32'h0);
        tick();
        applyStimulus(3'b010, 6'b000100, 12'h070, 1'b0);
        for (int j = 0; j < DEPTH; j++) begin
            bus.rd_addr = AW'(j);
            #1;
            checkOutput($sformatf("sw_busy%0d", j), 32'(bus.busy), 32'h1);
            checkOutput($sformatf("sw_gnt%0d", j),  32'(bus.gnt),  32'h0);
            checkOutput($sformatf("sw_old%0d", j),  32'(bus.rd_data), 32'(pre[j]));
            tick();
            checkOutput($sformatf("sw_zero%0d", j), 32'(bus.rd_data), 32'h0);
        end
        checkOutput("sw_done",     32'(bus.done), 32'h1);
        checkOutput("sw_idle",     32'(bus.busy), 32'h0);
        checkOutput("sw_resume",   32'(bus.gnt),  32'b010);
        tick();
        applyStimulus('0, '0, '0, 1'b0);
        checkOutput("sw_done_off", 32'(bus.done), 32'h0);
        readCheck("sw_wr1", 2'd1, 4'h7);
        readCheck("sw_rd0", 2'd0, 4'h0);

        $display("[TB] clr_start ignored mid-sweep");
        applyStimulus('0, '0, '0, 1'b1);
        tick();
        for (int c = 0; c < DEPTH; c++) begin
            applyStimulus('0, '0, '0, (c == 1));
            checkOutput($sformatf("re_busy%0d", c), 32'(bus.busy), 32'h1);
            checkOutput($sformatf("re_done%0d", c), 32'(bus.done), 32'h0);
            tick();
        end
        applyStimulus('0, '0, '0, 1'b0);
        checkOutput("re_end_busy", 32'(bus.busy), 32'h0);
        checkOutput("re_end_done", 32'(bus.done), 32'h1);
        tick();
        checkOutput("re_after_busy", 32'(bus.busy), 32'h0);
        checkOutput("re_after_done", 32'(bus.done), 32'h0);
        tick();
        checkOutput("re_once", 32'(bus.done), 32'h0);

        $display("[TB] async reset mid-sweep");
        applyStimulus(3'b001, 6'b000011, 12'h00B, 1'b0);
        tick();
        applyStimulus('0, '0, '0, 1'b1);
        tick();
        applyStimulus('0, '0, '0, 1'b0);
        tick();
        tick();
        readCheck("ar_pre", 2'd3, 4'hB);
        checkOutput("ar_pre_busy", 32'(bus.busy), 32'h1);
        reset = 1'b0;
        #1;
        checkOutput("ar_busy", 32'(bus.busy),    32'h0);
        checkOutput("ar_rd",   32'(bus.rd_data), 32'h0);
        checkOutput("ar_done", 32'(bus.done),    32'h0);
        reset = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            checkOutput($sformatf("ar_nodone%0d", n), 32'(bus.done), 32'h0);
        end

        $display("[TB] same address back to back");
        applyStimulus(3'b101, 6'b110011, 12'h905, 1'b0);
        checkOutput("ba_gnt0", 32'(bus.gnt), 32'b001);
        tick();
        applyStimulus(3'b100, 6'b110011, 12'h905, 1'b0);
        checkOutput("ba_gnt2", 32'(bus.gnt), 32'b100);
        readCheck("ba_first", 2'd3, 4'h5);
        tick();
        applyStimulus('0, '0, '0, 1'b0);
        readCheck("ba_last", 2'd3, 4'h9);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Controller that shares a bank of DEPTH asynchronously resettable WIDTH-bit registers between NREQ write requesters.
- Uses round-robin arbitration with a req/gnt handshake.
- Also runs a clear-sweep sequencer that zeroes the bank one register per cycle on command.
- Provides one combinational read port for downstream logic.

Parameters:
NREQ, 3, number of write requesters (2..8)
WIDTH, 4, register data width
DEPTH, 4, number of registers in the bank (power of two)
AW, 2, address width, equal to log2(DEPTH)

Ports:
clk  input  1  single clock; all state updates on its rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
req  input  NREQ  per-requester write request, held until granted
wr_addr  input  NREQ*AW  packed target addresses; requester i in slice [i*AW +: AW]
wr_data  input  NREQ*WIDTH  packed write data; requester i in slice [i*WIDTH +: WIDTH]
gnt  output  NREQ  one-hot grant, combinational; the write happens at the rising edge where gnt[i]=1
clr_start  input  1  single-cycle pulse that requests a clear sweep
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse when a sweep completes
rd_addr  input  AW  read address
rd_data  output  WIDTH  equals bank[rd_addr], combinational

Behaviour:
- Reset (reset=0, asynchronous):
  - All bank registers go to 0.
  - FSM goes to IDLE; sweep counter goes to 0.
  - Round-robin pointer last goes to NREQ-1, so requester 0 has top priority first.
  - gnt=0, busy=0, done=0.
  - Reset asserted mid-sweep aborts the sweep immediately; no done pulse is produced.
- FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP when clr_start=1 at a rising edge.
  - SWEEP -> IDLE at the edge where cnt=DEPTH-1 is cleared.
- Arbitration in IDLE:
  - If clr_start=0 and any req bit is 1, gnt is one-hot for the first requester found searching from last+1 upward, wrapping modulo NREQ.
  - At that rising edge the bank register at the granted requester's wr_addr is loaded with its wr_data, and last becomes the granted index.
  - With no request, gnt=0 and last holds.
- Handshake rules:
  - A requester keeps req, wr_addr and wr_data stable until the edge at which its gnt is 1.
  - It may drop req, or present a new transfer, in the following cycle.
  - A requester still holding req after its grant is granted again only after every other active requester has been served.
- Simultaneous clr_start and req in IDLE:
  - The clear takes priority: gnt=0 that cycle and no write occurs.
  - Requests stay pending.
- SWEEP:
  - busy=1 and gnt=0 throughout.
  - Each edge writes 0 to bank[cnt], then cnt increments.
  - The sweep takes exactly DEPTH cycles.
  - The cycle after the last clear, the FSM is in IDLE with busy=0 and done=1 for one cycle; arbitration resumes in that same cycle.
  - clr_start during SWEEP is ignored; there is no restart and no queuing.
  - The round-robin pointer is frozen during SWEEP.
- Read port:
  - rd_data reflects the registered bank contents.
  - A write becomes visible on rd_data after the writing edge; there is no write-through bypass.
- Two grants to the same address on consecutive cycles: the later write wins.
- Width rules:
  - Addresses are AW bits, so no out-of-range access is possible.
  - wr_data is stored as-is with no extension.

Test Plan:
- Reset then single write: release reset, req=3'b001, wr_addr0=2, wr_data0=4'hA -> gnt=3'b001 in the first cycle; rd_addr=2 gives rd_data=4'hA on the next cycle.
- Round-robin fairness: req=3'b111 held for 6 cycles after reset, with data 4'h1, 4'h2, 4'h3 to addresses 0, 1, 2 -> grant order 0,1,2,0,1,2 and the bank reads {1,2,3,0}.
- Clear sweep with contention: bank preloaded {F,E,D,C}, then clr_start pulse with req=3'b010 in the same cycle -> gnt=0 and busy=1 for 4 cycles, bank reads 0 at each address in turn, done=1 on cycle 5, and requester 1 is granted in that same cycle.
- clr_start re-pulsed mid-sweep on cycle 2 -> ignored; busy stays 1 for exactly 4 cycles and done pulses once.
- Async reset mid-sweep: assert reset=0 on cycle 2 between clock edges -> bank becomes 0 immediately, busy=0 without waiting for a clock edge, and no done pulse occurs after release.
- Back-to-back same address: requesters 0 and 2 both target address 3 with 4'h5 and 4'h9 -> after both grants (0 then 2), rd_data at address 3 is 4'h9.
